fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage feeding the decode stage. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and accepts the read response. Each fetched word is presented to decode with its PC, behind a two-entry output buffer (output register plus skid) so decode stalls never lose data. Branch/jump redirects flush everything fetched on the old path.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  read address (word aligned)
- imem_rsp_valid  in  1  read data valid; memory returns exactly one response per accepted request, in order, at least 1 cycle after acceptance
- imem_rsp_data  in  32  read data
- stall  in  1  decode cannot accept this cycle
- redirect_valid  in  1  load new PC, flush in-flight and buffered instructions
- redirect_pc  in  32  redirect target (bits [1:0] forced to 0 internally)
- instr  out  32  instruction to decode
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr/instr_pc valid

## Operation
- Registers: pc (next fetch address), out_addr (address of outstanding request), OUT (instr/instr_pc/instr_valid), SKID (data, pc, valid), drop flag, FSM.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: entered only by reset; next cycle -> REQ.
  - REQ: imem_req_valid = !SKID.valid; imem_addr = pc. On handshake (valid & ready): out_addr <= pc, pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0), -> WAIT.
  - WAIT: imem_req_valid = 0. On imem_rsp_valid -> REQ.
- Decode transfer occurs on any cycle with instr_valid & !stall.
- Response placement (drop = 0, no redirect): into OUT if OUT empty or transferring this cycle and SKID empty; otherwise into SKID. instr_pc/skid pc = out_addr.
- On a transfer with SKID valid: SKID moves to OUT, SKID cleared.
- Request gating on SKID empty guarantees a free slot for every response; no response is ever lost.
- OUT and SKID hold value while stall is high; instr/instr_pc never change while instr_valid & stall, except on redirect.
- Redirect (priority over all else): pc <= redirect_pc; OUT.valid and SKID.valid <= 0; FSM -> REQ. If a request is outstanding (WAIT, or handshake in the same cycle) and its response has not arrived, drop <= 1. A response arriving in the redirect cycle is discarded.
- Drop: next imem_rsp_valid with drop = 1 is discarded, drop <= 0, FSM -> REQ. No new request is issued while drop = 1 (single outstanding rule).
- imem_addr may change while imem_req_valid is high and unaccepted only due to a redirect.

## Timing
- Reset values: imem_req_valid 0, imem_addr RESET_PC, instr 0, instr_pc 0, instr_valid 0, pc RESET_PC, drop 0, FSM IDLE.
- First request: imem_req_valid high 1 cycle after rst_n deasserts.
- Latency: response at cycle t -> instr_valid at t+1. Next request issued at t+1.
- Throughput with 1-cycle memory, no stall: one instruction per 2 cycles.
- Redirect at cycle t: instr_valid 0 at t+1; request to redirect_pc at t+1 if nothing outstanding, else cycle after the dropped response.
- Reset asserted mid-transaction: all state returns to reset values immediately; memory side is reset by the same rst_n.

## Test plan
- Reset, RESET_PC = 0x100, ready=1, 1-cycle memory, no stall -> requests 0x100, 0x104, 0x108; instr_valid pulses with instr_pc 0x100, 0x104, 0x108 in order, each one cycle after its response.
- stall held 6 cycles after first instr valid -> OUT holds 0x100 word, SKID captures 0x104, no further requests; release -> 0x100 then 0x104 delivered in consecutive cycles, then 0x108 requested.
- imem_req_ready low 3 cycles -> imem_req_valid/imem_addr 0x100 held stable; fetch proceeds after ready.
- Redirect to 0x200 while request 0x104 outstanding (3-cycle memory) -> 0x104 response discarded, instr_valid 0, next request 0x200, next delivered instr_pc 0x200.
- Redirect in same cycle as response and with OUT/SKID full under stall -> all three discarded, next request 0x200 next cycle.
- pc = 0xFFFF_FFFC redirect -> fetches 0xFFFF_FFFC then 0x0000_0000; rst_n pulse mid-WAIT -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the program counter, issues one instruction
// memory read at a time, and hands fetched words to decode through a
// two-entry buffer (output register plus skid register). A redirect loads a
// new PC and flushes everything fetched on the old path, including a read
// that is still in flight.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;          // next fetch address
    logic [31:0] r_out_addr;    // address of the outstanding read
    logic        r_drop;        // next response belongs to a flushed path

    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] r_skid_data;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;

    logic        w_req_valid;
    logic        w_hs;
    logic        w_xfer;
    logic        w_rsp_take;
    logic        w_drop_on_redirect;

    assign w_hs       = w_req_valid & imem_req_ready;
    assign w_xfer     = r_instr_valid & ~stall;
    // A response is kept only when it answers a live-path request.
    assign w_rsp_take = imem_rsp_valid & ~r_drop & (r_state == ST_WAIT);

    // A redirect must discard a read that is still in flight: one waiting in
    // WAIT, one being accepted right now, or an already-flushed one that is
    // still pending. A response arriving this cycle is discarded directly.
    assign w_drop_on_redirect = ((r_state == ST_WAIT) & ~imem_rsp_valid)
                              | w_hs
                              | (r_drop & ~imem_rsp_valid);

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_valid    = r_instr_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and request valid; requests only go out when the skid
    // slot is free and no flushed read is pending, so every response fits.
    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                w_req_valid = ~r_skid_valid & ~r_drop;
                if (w_req_valid && imem_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (redirect_valid) begin
            w_state_next = ST_REQ;
        end
    end

    // Program counter, outstanding-address capture and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_out_addr <= RESET_PC;
            r_drop     <= 1'b0;
        end else if (redirect_valid) begin
            r_pc   <= redirect_pc & ~32'h0000_0003;
            r_drop <= w_drop_on_redirect;
        end else begin
            if (w_hs) begin
                r_out_addr <= r_pc;
                r_pc       <= r_pc + 32'd4;
            end
            if (r_drop && imem_rsp_valid) begin
                r_drop <= 1'b0;
            end
        end
    end

    // Output register and skid register: responses fill the output register
    // when it is free (or emptying), otherwise the skid; a transfer promotes
    // the skid entry into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
            r_skid_data   <= 32'd0;
            r_skid_pc     <= 32'd0;
            r_skid_valid  <= 1'b0;
        end else if (redirect_valid) begin
            r_instr_valid <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                r_instr       <= r_skid_data;
                r_instr_pc    <= r_skid_pc;
                r_instr_valid <= 1'b1;
                if (w_rsp_take) begin
                    r_skid_data <= imem_rsp_data;
                    r_skid_pc   <= r_out_addr;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_rsp_take) begin
                r_instr       <= imem_rsp_data;
                r_instr_pc    <= r_out_addr;
                r_instr_valid <= 1'b1;
            end else begin
                r_instr_valid <= 1'b0;
            end
        end else if (w_rsp_take) begin
            if (!r_instr_valid) begin
                r_instr       <= imem_rsp_data;
                r_instr_pc    <= r_out_addr;
                r_instr_valid <= 1'b1;
            end else begin
                r_skid_data  <= imem_rsp_data;
                r_skid_pc    <= r_out_addr;
                r_skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder with configurable latency, a
// transaction-level model (expected fetch address, pending reads tagged with
// a path epoch, queue of words decode still has to receive) checked every
// cycle, plus directed scenarios with hand-computed request/delivery times.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid)
    );

    typedef struct packed { logic [31:0] addr; int cyc; } log_t;
    typedef struct packed { logic [31:0] addr; int ep;  } pend_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } item_t;
    typedef struct packed { logic [31:0] addr; int due; } mem_t;

    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    int    base = 0;
    int    lat = 1;

    log_t  req_log[$];
    log_t  del_log[$];
    mem_t  mq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Memory: accepts reads, answers each one lat cycles later, in order.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
                if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});
            end
            @(posedge clk);
            #1;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mdata(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'd0;
            end
        end
    end

    // Model state and per-cycle compare.
    logic [31:0] exp_next = RST_PC;
    int          epoch = 0;
    pend_t       pend[$];
    item_t       dq[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_imem_addr", imem_addr, RST_PC);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
            exp_next  = RST_PC;
            pend.delete();
            dq.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                chk("req_hold_addr", imem_addr, prev_addr);
            end
            if (imem_req_valid) begin
                chk("req_addr", imem_addr, exp_next);
                chk("req_single_outstanding", 32'(pend.size()), 32'd0);
            end
            if (dq.size() >= 2) chk("req_gated_when_full", 32'(imem_req_valid), 32'd0);
            chk("instr_valid", 32'(instr_valid), 32'(dq.size() > 0));
            if (instr_valid && dq.size() > 0) begin
                chk("instr_pc", instr_pc, dq[0].pc);
                chk("instr_data", instr, dq[0].data);
            end
            if (imem_req_valid && imem_req_ready) req_log.push_back('{imem_addr, cyc - base});
            if (instr_valid && !stall) del_log.push_back('{instr_pc, cyc - base});
            // advance the model to the state after the coming edge
            if (instr_valid && !stall && dq.size() > 0) void'(dq.pop_front());
            if (imem_rsp_valid && pend.size() > 0) begin
                pend_t p;
                p = pend.pop_front();
                if (!redirect_valid && p.ep == epoch) dq.push_back('{p.addr, mdata(p.addr)});
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{exp_next, epoch});
                exp_next = exp_next + 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                dq.delete();
                exp_next = redirect_pc & ~32'h3;
            end
            prev_hold = imem_req_valid & ~imem_req_ready & ~redirect_valid;
            prev_addr = imem_addr;
        end
    end

    task automatic do_reset(int l, logic rdy, logic stl);
        rst_n          = 1'b0;
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        lat            = l;
        repeat (2) @(posedge clk);
        #1;
        req_log.delete();
        del_log.delete();
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic go(int k);
        while (cyc - base < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_req(int i, logic [31:0] a, int c);
        if (i < req_log.size()) begin
            chk($sformatf("req%0d_addr", i), req_log[i].addr, a);
            chk($sformatf("req%0d_cycle", i), 32'(req_log[i].cyc), 32'(c));
        end else begin
            chk($sformatf("req%0d_present", i), 32'(req_log.size()), 32'(i + 1));
        end
    endtask

    task automatic chk_del(int i, logic [31:0] a, int c);
        if (i < del_log.size()) begin
            chk($sformatf("del%0d_pc", i), del_log[i].addr, a);
            chk($sformatf("del%0d_cycle", i), 32'(del_log[i].cyc), 32'(c));
        end else begin
            chk($sformatf("del%0d_present", i), 32'(del_log.size()), 32'(i + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #1;

        // Streaming, 1-cycle memory, no stall.
        do_reset(1, 1'b1, 1'b0);
        go(12);
        chk_req(0, 32'h100, 1);
        chk_req(1, 32'h104, 3);
        chk_req(2, 32'h108, 5);
        chk_del(0, 32'h100, 3);
        chk_del(1, 32'h104, 5);
        chk_del(2, 32'h108, 7);
        $display("scenario stream: %0d/%0d so far", n_pass, n_total);

        // Decode stall for 6 cycles: output holds 0x100, skid takes 0x104.
        do_reset(1, 1'b1, 1'b0);
        go(3);
        stall = 1'b1;
        go(7);
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_pc", instr_pc, 32'h100);
        go(9);
        stall = 1'b0;
        go(11);
        chk_del(0, 32'h100, 9);
        chk_del(1, 32'h104, 10);
        chk_req(2, 32'h108, 10);
        $display("scenario stall: %0d/%0d so far", n_pass, n_total);

        // Memory not ready for 3 cycles.
        do_reset(1, 1'b0, 1'b0);
        go(2);
        chk("notready_valid", 32'(imem_req_valid), 32'd1);
        chk("notready_addr", imem_addr, 32'h100);
        go(4);
        imem_req_ready = 1'b1;
        go(8);
        chk_req(0, 32'h100, 4);
        chk_del(0, 32'h100, 6);
        $display("scenario ready: %0d/%0d so far", n_pass, n_total);

        // Redirect while 0x104 is outstanding, 3-cycle memory.
        do_reset(3, 1'b1, 1'b0);
        go(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        go(7);
        redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(instr_valid), 32'd0);
        go(15);
        chk_req(1, 32'h104, 5);
        chk_req(2, 32'h200, 9);
        chk_del(0, 32'h100, 5);
        chk_del(1, 32'h200, 13);
        $display("scenario redirect_wait: %0d/%0d so far", n_pass, n_total);

        // Redirect in the same cycle as a response, output register full under stall.
        do_reset(1, 1'b1, 1'b1);
        go(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        go(5);
        redirect_valid = 1'b0;
        chk("redir_rsp_valid", 32'(instr_valid), 32'd0);
        chk("redir_rsp_req", 32'(imem_req_valid), 32'd1);
        chk("redir_rsp_addr", imem_addr, 32'h200);
        go(7);
        chk("redir_rsp_new_valid", 32'(instr_valid), 32'd1);
        chk("redir_rsp_new_pc", instr_pc, 32'h200);
        chk("redir_rsp_new_data", instr, 32'h5A5A_C1C3);
        $display("scenario redirect_rsp: %0d/%0d so far", n_pass, n_total);

        // Redirect with output and skid both full.
        do_reset(1, 1'b1, 1'b1);
        go(6);
        chk("full_no_req", 32'(imem_req_valid), 32'd0);
        chk("full_instr_pc", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        go(7);
        redirect_valid = 1'b0;
        chk("full_flush_valid", 32'(instr_valid), 32'd0);
        chk("full_req_valid", 32'(imem_req_valid), 32'd1);
        chk("full_req_addr", imem_addr, 32'h300);
        go(9);
        stall = 1'b0;
        go(12);
        chk_del(0, 32'h300, 9);
        $display("scenario redirect_full: %0d/%0d so far", n_pass, n_total);

        // Redirect to the top word during a handshake: wraps to 0.
        do_reset(1, 1'b1, 1'b0);
        go(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        go(2);
        redirect_valid = 1'b0;
        go(9);
        chk_req(0, 32'h100, 1);
        chk_req(1, 32'hFFFF_FFFC, 3);
        chk_req(2, 32'h0000_0000, 5);
        chk_del(0, 32'hFFFF_FFFC, 5);
        chk_del(1, 32'h0000_0000, 7);
        $display("scenario wrap: %0d/%0d so far", n_pass, n_total);

        // Asynchronous reset pulse while a read is outstanding.
        do_reset(1, 1'b1, 1'b0);
        go(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_addr", imem_addr, RST_PC);
        chk("async_instr_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_instr_pc", instr_pc, 32'd0);
        do_reset(1, 1'b1, 1'b0);
        go(5);
        chk_req(0, 32'h100, 1);
        chk_del(0, 32'h100, 3);
        $display("scenario async_reset: %0d/%0d so far", n_pass, n_total);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
